// File: rtl/fetch_stage.sv
// Instruction fetch stage with PC, word-addressed instruction memory and IF/ID register.
// Taken branches redirect the PC and flush IF/ID; stalls freeze both.
module fetch_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h00000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          stall,
    input  logic                          branch,
    input  logic                          zero,
    input  logic [31:0]                   imm_ext,
    input  logic                          imem_we,
    input  logic [$clog2(IMEM_DEPTH)-1:0] imem_waddr,
    input  logic [31:0]                   imem_wdata,
    output logic [31:0]                   pc,
    output logic [31:0]                   id_instr,
    output logic                          id_valid,
    output logic [31:0]                   id_pc_plus4,
    output logic [5:0]                    opc,
    output logic [5:0]                    funct
);

    localparam int AW = $clog2(IMEM_DEPTH);

    logic [31:0] imem [IMEM_DEPTH];
    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;
    logic [31:0]   pc_plus4;
    logic [31:0]   branch_target;
    logic          branch_taken;

    // Upper PC bits are dropped, so fetch addresses wrap around the memory.
    assign fetch_idx     = pc[AW+1:2];
    assign fetch_word    = imem[fetch_idx];
    assign pc_plus4      = pc + 32'd4;
    assign branch_target = id_pc_plus4 + (imm_ext << 2);
    assign branch_taken  = branch & zero & id_valid;

    // Memory is never cleared; loads are honoured even in reset or stall.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            imem[imem_waddr] <= imem_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc          <= RESET_PC;
            id_instr    <= 32'h0;
            id_valid    <= 1'b0;
            id_pc_plus4 <= 32'h0;
        end else if (branch_taken) begin
            pc          <= branch_target;
            id_instr    <= 32'h0;
            id_valid    <= 1'b0;
            id_pc_plus4 <= 32'h0;
        end else if (!stall) begin
            pc          <= pc_plus4;
            id_instr    <= fetch_word;
            id_valid    <= 1'b1;
            id_pc_plus4 <= pc_plus4;
        end
    end

    assign opc   = id_instr[31:26];
    assign funct = id_instr[5:0];

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: directed steps queue the expected post-edge
// state, and a monitor compares it one time unit after each rising edge.
module tb_fetch_stage;

    logic        clk;
    logic        reset;
    logic        stall;
    logic        branch;
    logic        zero;
    logic [31:0] imm_ext;
    logic        imem_we;
    logic [5:0]  imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] id_instr;
    logic        id_valid;
    logic [31:0] id_pc_plus4;
    logic [5:0]  opc;
    logic [5:0]  funct;

    fetch_stage #(.IMEM_DEPTH(64), .RESET_PC(32'h0)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch(branch), .zero(zero),
        .imm_ext(imm_ext), .imem_we(imem_we), .imem_waddr(imem_waddr),
        .imem_wdata(imem_wdata), .pc(pc), .id_instr(id_instr), .id_valid(id_valid),
        .id_pc_plus4(id_pc_plus4), .opc(opc), .funct(funct)
    );

    typedef struct packed {
        logic [15:0] tag;
        logic [31:0] pc;
        logic [31:0] instr;
        logic        valid;
        logic [31:0] pp4;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;
    int   step_no  = 0;

    localparam logic [31:0] W0 = 32'h8C010004, W1 = 32'hAC010008, W2 = 32'h10000002,
                            W3 = 32'h00000020, W4 = 32'h20010001, W5 = 32'h20020002,
                            W6 = 32'h20030003, W7 = 32'h20040004, W63 = 32'h3C01ABCD;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (sb.size() > 0) begin
            e = sb.pop_front();
            n_checks++;
            if (pc !== e.pc || id_instr !== e.instr || id_valid !== e.valid ||
                id_pc_plus4 !== e.pp4 || opc !== e.instr[31:26] || funct !== e.instr[5:0]) begin
                $display("FAIL step%0d: got pc=%h instr=%h valid=%b pp4=%h opc=%b funct=%b, want pc=%h instr=%h valid=%b pp4=%h opc=%b funct=%b",
                         e.tag, pc, id_instr, id_valid, id_pc_plus4, opc, funct,
                         e.pc, e.instr, e.valid, e.pp4, e.instr[31:26], e.instr[5:0]);
            end else begin
                n_pass++;
            end
        end
    end

    task automatic step(input logic [31:0] p, input logic [31:0] i, input logic v,
                        input logic [31:0] q);
        exp_t e;
        step_no++;
        e.tag   = 16'(step_no);
        e.pc    = p;
        e.instr = i;
        e.valid = v;
        e.pp4   = q;
        sb.push_back(e);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load(input logic [5:0] idx, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = idx;
        imem_wdata = data;
        step(32'h0, 32'h0, 1'b0, 32'h0);
        imem_we    = 1'b0;
    endtask

    initial begin
        reset = 1'b1; stall = 1'b0; branch = 1'b0; zero = 1'b0; imm_ext = 32'h0;
        imem_we = 1'b0; imem_waddr = 6'd0; imem_wdata = 32'h0;
        @(negedge clk);

        // Load program while held in reset.
        load(6'd0, W0); load(6'd1, W1); load(6'd2, W2); load(6'd3, W3);
        load(6'd4, W4); load(6'd5, W5); load(6'd6, W6); load(6'd7, W7);
        load(6'd63, W63);

        // Release with a branch request while IF/ID is empty: must not redirect.
        reset = 1'b0; branch = 1'b1; zero = 1'b1; imm_ext = 32'd5;
        step(32'h4, W0, 1'b1, 32'h4);
        branch = 1'b0; zero = 1'b0;
        step(32'h8, W1, 1'b1, 32'h8);

        // Stall three cycles at pc=8.
        stall = 1'b1;
        for (int k = 0; k < 3; k++) step(32'h8, W1, 1'b1, 32'h8);
        stall = 1'b0;
        step(32'hC, W2, 1'b1, 32'hC);

        // Taken forward branch: target C + 8 = 14, one bubble, then imem[5].
        branch = 1'b1; zero = 1'b1; imm_ext = 32'd2;
        step(32'h14, 32'h0, 1'b0, 32'h0);
        branch = 1'b0; zero = 1'b0;
        step(32'h18, W5, 1'b1, 32'h18);
        step(32'h1C, W6, 1'b1, 32'h1C);

        // Branch without zero: sequential.
        branch = 1'b1; zero = 1'b0;
        step(32'h20, W7, 1'b1, 32'h20);

        // Reset beats stall and a taken branch.
        reset = 1'b1; stall = 1'b1; branch = 1'b1; zero = 1'b1;
        step(32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b0; stall = 1'b0; branch = 1'b0; zero = 1'b0;
        step(32'h4, W0, 1'b1, 32'h4);
        step(32'h8, W1, 1'b1, 32'h8);
        step(32'hC, W2, 1'b1, 32'hC);
        step(32'h10, W3, 1'b1, 32'h10);

        // Backward taken branch under stall: 10 + (-2<<2) = 8, flushed.
        branch = 1'b1; zero = 1'b1; stall = 1'b1; imm_ext = 32'hFFFFFFFE;
        step(32'h8, 32'h0, 1'b0, 32'h0);
        branch = 1'b0; zero = 1'b0; stall = 1'b0;
        step(32'hC, W2, 1'b1, 32'hC);

        // Jump to the last word, then fetch across the wrap.
        branch = 1'b1; zero = 1'b1; imm_ext = 32'h3C;
        step(32'hFC, 32'h0, 1'b0, 32'h0);
        branch = 1'b0; zero = 1'b0;
        step(32'h100, W63, 1'b1, 32'h100);
        step(32'h104, W0, 1'b1, 32'h104);

        // Reset, then overwrite index 1 while it is being fetched.
        reset = 1'b1;
        step(32'h0, 32'h0, 1'b0, 32'h0);
        reset = 1'b0;
        step(32'h4, W0, 1'b1, 32'h4);
        imem_we = 1'b1; imem_waddr = 6'd1; imem_wdata = 32'hDEADBEEF;
        step(32'h8, W1, 1'b1, 32'h8);
        imem_we = 1'b0;
        branch = 1'b1; zero = 1'b1; imm_ext = 32'hFFFFFFFF;
        step(32'h4, 32'h0, 1'b0, 32'h0);
        branch = 1'b0; zero = 1'b0;
        step(32'h8, 32'hDEADBEEF, 1'b1, 32'h8);

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        if (sb.size() > 0) begin
            $display("FAIL drain: got %0d pending entries, want 0", sb.size());
            n_checks++;
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- Instruction-fetch stage plus IF/ID pipeline register for the single-issue MIPS datapath.
- Holds the PC and a word-addressed instruction memory, and registers the fetched word.
- Drives opc/funct straight into the control unit, plus pc_plus4 for branch-target arithmetic.
- Accepts branch resolution (branch from control, zero from ALU) and a stall from hazard logic.

Parameters:
IMEM_DEPTH, 64, instruction memory depth in 32-bit words (power of two)
RESET_PC, 32'h00000000, PC value loaded on reset

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  synchronous, active-high reset
stall  input  1  hold PC and IF/ID register this cycle
branch  input  1  control-unit branch for the instruction in ID
zero  input  1  ALU zero flag for the instruction in ID
imm_ext  input  32  sign-extended immediate of the instruction in ID
imem_we  input  1  instruction-memory load strobe
imem_waddr  input  log2(IMEM_DEPTH)  word index to load
imem_wdata  input  32  word to load
pc  output  32  current fetch PC
id_instr  output  32  IF/ID instruction
id_valid  output  1  IF/ID holds a real instruction
id_pc_plus4  output  32  PC+4 of the IF/ID instruction
opc  output  6  id_instr[31:26], to control unit
funct  output  6  id_instr[5:0], to control unit

Behaviour:
- Reset has priority over everything:
  - pc=RESET_PC, id_instr=0, id_valid=0, id_pc_plus4=0.
  - opc and funct are therefore 0, an sll-nop encoding.
  - Instruction memory contents are not cleared.
- Fetch path:
  - Memory read is combinational at index pc[2+log2(IMEM_DEPTH)-1:2].
  - Upper PC bits are ignored, so addresses wrap modulo IMEM_DEPTH words.
  - pc[1:0] is always 00 by construction.
- Latency: the word at PC p appears on id_instr one cycle after pc==p, with id_pc_plus4=p+4.
- branch_taken = branch & zero & id_valid. Branch is ignored while id_valid=0.
- Per-cycle priority when not in reset:
  1. branch_taken:
     - pc <= id_pc_plus4 + (imm_ext << 2), 32-bit wrap, overflow discarded.
     - IF/ID is flushed: id_instr=0, id_valid=0, id_pc_plus4=0.
     - Flush wins over a simultaneous stall.
  2. stall (no branch_taken): pc, id_instr, id_valid and id_pc_plus4 all hold.
  3. Otherwise:
     - pc <= pc+4 (wraps at 2^32).
     - id_instr <= imem[pc]; id_valid <= 1; id_pc_plus4 <= pc+4.
- Branch timing: the instruction fetched in the same cycle as the taken branch is discarded. There is one bubble per taken branch and no delay slot.
- Loads through imem_we:
  - The write lands at the clock edge.
  - A same-cycle fetch from the same index returns the old word; the new word is visible from the next cycle.
  - Loads are allowed during reset and during stall.
- opc and funct are pure slices of id_instr and update in the same cycle as id_instr.
- Negative imm_ext gives backward branches. A target below 0 wraps modulo 2^32, then modulo IMEM_DEPTH for the memory index.

Test Plan:
- Reset sequential fetch:
  - Stimulus: load imem[0..3] = 8C010004, AC010008, 10000002, 00000020; reset 2 cycles, then release.
  - Required: pc steps 0,4,8,C.
  - Required: id_instr one cycle behind, with opc 100011, 101011, 000100, 000000 in turn and funct=100000 on the last.
  - Required: id_valid=1 from the first post-reset edge.
- Stall hold:
  - Stimulus: assert stall 3 cycles with pc=8.
  - Required: pc stays 8; id_instr/id_pc_plus4 frozen at AC010008/8.
  - Required: on release, pc=C next edge.
- Taken branch with flush:
  - Stimulus: id_instr=10000002 with id_pc_plus4=C; branch=1, zero=1, imm_ext=2.
  - Required: next pc=14; id_valid=0; id_instr=0.
  - Required: following cycle id_instr=imem[5] with id_pc_plus4=18.
- Not-taken and gated branch:
  - Stimulus A: branch=1, zero=0 → sequential pc+4, no flush.
  - Stimulus B: branch=1, zero=1 while id_valid=0 (directly after reset) → no redirect.
- Branch over stall, backward and wrap:
  - Stimulus A: branch_taken together with stall=1, imm_ext=FFFFFFFE, id_pc_plus4=10 → pc=8, IF/ID flushed.
  - Stimulus B: sequential fetch from pc=(IMEM_DEPTH-1)*4 → next fetch reads imem[0] at pc=IMEM_DEPTH*4.
- Reset mid-run and write-read collision:
  - Stimulus A: reset asserted while stall=1 and branch_taken → pc=RESET_PC, id_valid=0.
  - Stimulus B: imem_we to index 1 in the same cycle pc=4 → id_instr gets the old word.
  - Required for B: the refetched index 1 returns the new word.
